// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-stage state encoding.
// Opcodes occupy ins[31:26].
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_MOVE  = 6'b010010;
    localparam logic [5:0] OP_PUSH  = 6'b010011;
    localparam logic [5:0] OP_POP   = 6'b010100;
    localparam logic [5:0] OP_CALL  = 6'b010101;
    localparam logic [5:0] OP_HALT  = 6'b010110;
    localparam logic [5:0] OP_NOP   = 6'b010111;
    localparam logic [5:0] OP_RET   = 6'b011000;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_PC_STEP  = 4;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DROP    = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    typedef enum logic [1:0] {
        FETCH   = ST_FETCH,
        DROP    = ST_DROP,
        DELIVER = ST_DELIVER,
        HALTED  = ST_HALTED
    } fetch_state_t;

    function automatic logic is_halt(input logic [31:0] word);
        return word[31:26] == OP_HALT;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory req/ack handshake.
// master = fetch unit, slave = memory.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches over req/ack, delivers one
// instruction at a time, squashes on redirect, stops on HALT.
module instruction_fetch_unit
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  imem,
    output logic [31:0]               ins,
    output logic                      ins_valid,
    input  logic                      ins_ready,
    output logic [ADDR_W-1:0]         pc_out,
    output logic [ADDR_W-1:0]         npc_out,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      halted,
    output logic [31:0]               fetch_count
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
    logic [ADDR_W-1:0] pc_out_nxt;
    logic [31:0]       ins_nxt;
    logic              ins_valid_nxt;
    logic              halted_nxt;
    logic [31:0]       fetch_count_nxt;

    // Gated by rst so the request drops the instant reset asserts.
    assign imem.imem_req  = !rst && (state == FETCH || state == DROP);
    assign imem.imem_addr = fetch_addr;
    assign npc_out        = pc_out + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RST_PC;
            fetch_addr  <= RST_PC;
            pc_out      <= RST_PC;
            ins         <= '0;
            ins_valid   <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_addr  <= fetch_addr_nxt;
            pc_out      <= pc_out_nxt;
            ins         <= ins_nxt;
            ins_valid   <= ins_valid_nxt;
            halted      <= halted_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        fetch_addr_nxt  = fetch_addr;
        pc_out_nxt      = pc_out;
        ins_nxt         = ins;
        ins_valid_nxt   = ins_valid;
        halted_nxt      = halted;
        fetch_count_nxt = fetch_count;

        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    if (imem.imem_ack) fetch_addr_nxt = redirect_pc;
                    else state_nxt = DROP;
                end else if (imem.imem_ack) begin
                    ins_nxt       = imem.imem_rdata;
                    pc_out_nxt    = fetch_addr;
                    ins_valid_nxt = 1'b1;
                    state_nxt     = DELIVER;
                end
            end
            DROP: begin
                // Old address stays on the bus until the memory answers.
                if (redirect_valid) pc_nxt = redirect_pc;
                if (imem.imem_ack) begin
                    fetch_addr_nxt = pc_nxt;
                    state_nxt      = FETCH;
                end
            end
            DELIVER: begin
                if (redirect_valid) begin
                    ins_valid_nxt  = 1'b0;
                    pc_nxt         = redirect_pc;
                    fetch_addr_nxt = redirect_pc;
                    state_nxt      = FETCH;
                end else if (ins_ready) begin
                    ins_valid_nxt   = 1'b0;
                    fetch_count_nxt = fetch_count + 32'd1;
                    if (is_halt(ins)) begin
                        halted_nxt = 1'b1;
                        state_nxt  = HALTED;
                    end else begin
                        pc_nxt         = pc + STEP;
                        fetch_addr_nxt = pc + STEP;
                        state_nxt      = FETCH;
                    end
                end
            end
            HALTED: begin
                ins_valid_nxt = 1'b0;
                halted_nxt    = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, stall,
// redirects, HALT, PC wrap and async reset.
module tb_instruction_fetch_unit;

    localparam logic [31:0] W_ADD0 = 32'h0022_1820;
    localparam logic [31:0] W_ADD1 = 32'h0043_2020;
    localparam logic [31:0] W_NOP  = 32'h5C00_0000;
    localparam logic [31:0] W_HALT = 32'h5800_0000;
    localparam logic [31:0] W_JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] ins, pc_out, npc_out, fetch_count;
    logic        ins_valid, halted;
    int          checks = 0;
    int          errors = 0;

    instruction_fetch_unit_if #(.ADDR_W(32)) imem ();

    instruction_fetch_unit #(
        .ADDR_W(32), .RESET_PC(0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .pc_out(pc_out), .npc_out(npc_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word with ack one cycle after req, then accept it.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word,
                             input logic [31:0] cnt_after);
        chk("req_on", {31'd0, imem.imem_req}, 32'd1);
        chk("req_addr", imem.imem_addr, addr);
        tick();
        chk("req_held", {31'd0, imem.imem_req}, 32'd1);
        imem.imem_ack = 1'b1;
        imem.imem_rdata = word;
        tick();
        imem.imem_ack = 1'b0;
        chk("valid", {31'd0, ins_valid}, 32'd1);
        chk("ins", ins, word);
        chk("pc_out", pc_out, addr);
        chk("npc_out", npc_out, addr + 32'd4);
        chk("req_off", {31'd0, imem.imem_req}, 32'd0);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("count", fetch_count, cnt_after);
        chk("valid_drop", {31'd0, ins_valid}, 32'd0);
    endtask

    initial begin
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;

        // Reset state
        tick();
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        rst = 1'b0;
        #1;

        // 1: sequential fetch 0,4,8
        fetch_one(32'h0, W_ADD0, 32'd1);
        fetch_one(32'h4, W_ADD1, 32'd2);
        fetch_one(32'h8, W_NOP, 32'd3);

        // 2: stall in DELIVER (ack in the first req cycle)
        chk("t2_addr", imem.imem_addr, 32'hC);
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_ADD1;
        tick();
        imem.imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_ins", ins, W_ADD1);
            chk("t2_pc", pc_out, 32'hC);
            chk("t2_req", {31'd0, imem.imem_req}, 32'd0);
            chk("t2_cnt", fetch_count, 32'd3);
            chk("t2_valid", {31'd0, ins_valid}, 32'd1);
            tick();
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("t2_cnt_acc", fetch_count, 32'd4);
        chk("t2_next", imem.imem_addr, 32'h10);

        // 3: redirect while request pending
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t3_req", {31'd0, imem.imem_req}, 32'd1);
            chk("t3_hold", imem.imem_addr, 32'h10);
            tick();
        end
        chk("t3_hold2", imem.imem_addr, 32'h10);
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_JUNK;
        tick();
        imem.imem_ack = 1'b0;
        chk("t3_novalid", {31'd0, ins_valid}, 32'd0);
        chk("t3_addr", imem.imem_addr, 32'h100);
        chk("t3_req2", {31'd0, imem.imem_req}, 32'd1);
        chk("t3_cnt", fetch_count, 32'd4);

        // 4: redirect with ack, then redirect beating ins_ready
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_JUNK;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        imem.imem_ack = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_novalid", {31'd0, ins_valid}, 32'd0);
        chk("t4_addr", imem.imem_addr, 32'h40);
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_ADD0;
        tick();
        imem.imem_ack = 1'b0;
        chk("t4_valid", {31'd0, ins_valid}, 32'd1);
        chk("t4_pc", pc_out, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        ins_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        ins_ready = 1'b0;
        chk("t4_squash", {31'd0, ins_valid}, 32'd0);
        chk("t4_cnt", fetch_count, 32'd4);
        chk("t4_addr2", imem.imem_addr, 32'h80);

        // 5: HALT
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_HALT;
        tick();
        imem.imem_ack = 1'b0;
        chk("t5_ins", ins, W_HALT);
        chk("t5_halt_pre", {31'd0, halted}, 32'd0);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_cnt", fetch_count, 32'd5);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = i[0];
            redirect_pc = 32'h300;
            imem.imem_ack = ~i[0];
            chk("t5_req", {31'd0, imem.imem_req}, 32'd0);
            chk("t5_valid", {31'd0, ins_valid}, 32'd0);
            chk("t5_hold", {31'd0, halted}, 32'd1);
            tick();
        end
        redirect_valid = 1'b0;
        imem.imem_ack = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_rst_halt", {31'd0, halted}, 32'd0);
        chk("t5_rst_pc", pc_out, 32'd0);
        chk("t5_rst_cnt", fetch_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_req_after", {31'd0, imem.imem_req}, 32'd1);
        chk("t5_addr_after", imem.imem_addr, 32'h0);

        // 6: PC wrap, then async reset while in DROP
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = W_JUNK;
        tick();
        imem.imem_ack = 1'b0;
        fetch_one(32'hFFFF_FFFC, W_ADD0, 32'd1);
        chk("t6_wrap", imem.imem_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("t6_drop_req", {31'd0, imem.imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_arst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("t6_arst_cnt", fetch_count, 32'd0);
        chk("t6_arst_pc", pc_out, 32'd0);
        chk("t6_arst_addr", imem.imem_addr, 32'd0);
        chk("t6_arst_ins", ins, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
